i2c_target_regfile: RTL
=======================

# i2c_target_regfile

I2C target (responder) that presents a small byte-addressed register file on the bus at a fixed 7-bit address. It is the far end of the team's I2C master read/write flow. It decodes START/STOP, matches the address, accepts a register-pointer byte, then serves write bytes or read bytes with pointer auto-increment. It runs from the system clock by oversampling SCL/SDA, drives SDA open-drain, and exposes write events plus a registered host read port to local logic.

## Interface
- `ADDR`, default 7'h50: 7-bit target address matched against the address byte.
- `DEPTH`, default 8: number of 8-bit registers; must be a power of two; `AW = log2(DEPTH)`.
- `clk` input 1: system clock; all state is on its rising edge. One clock domain only.
- `rst` input 1: reset, asynchronous and active-high.
- `scl_i` input 1: bus SCL, asynchronous to `clk`.
- `sda_i` input 1: bus SDA, asynchronous to `clk`.
- `sda_oe` output 1: 1 = pull SDA low, 0 = release. The top level builds the tri-state as `(sda_oe) ? 1'b0 : 1'bZ`.
- `wr_valid` output 1: one-cycle pulse when an I2C data byte is committed to the register file.
- `wr_addr` output AW: register index of the committed byte.
- `wr_data` output 8: committed byte.
- `rd_addr` input AW: host read index.
- `rd_data` output 8: `mem[rd_addr]`, registered.
- `busy` output 1: 1 from START detect until STOP detect.

## Operation
- **Reset values:**
  - `sda_oe`, `wr_valid`, `busy` = 0.
  - `wr_addr`, `wr_data`, `rd_data` = 0.
  - Pointer = 0; all `mem` bytes = 0; state = IDLE.
- **Input conditioning:** `scl_i` and `sda_i` each pass through a 2-flop synchronizer, then a third flop for edge detection.
- **Bus events** (on synchronized signals):
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Data bits are sampled on the SCL rise.
  - `sda_oe` changes only on a detected SCL fall.
- **Event priority:** START/STOP override everything in the same cycle.
  - START, including a repeated start: go to ADDR, clear the bit counter, release `sda_oe`, keep the pointer.
  - STOP: go to IDLE, release `sda_oe`. A partial byte is discarded with no write.
- **State machine:**
  - **IDLE:** wait for START.
  - **ADDR:** shift in 8 bits, MSB first. On the 8th rise:
    - If `byte[7:1]==ADDR`, latch R/W and go to ADDR_ACK.
    - Otherwise go to IGNORE.
  - **IGNORE:** `sda_oe` stays 0; wait for START/STOP.
  - **ADDR_ACK:** `sda_oe`=1 from the SCL fall after bit 8 to the SCL fall after the 9th clock. At that fall:
    - R/W=1: go to RDATA, load the shift register with `mem[ptr]`, and drive the MSB.
    - R/W=0: go to REG.
  - **REG:** receive 8 bits, then `ptr <= byte[AW-1:0]` (upper bits ignored). ACK, then go to WDATA.
  - **WDATA:** receive 8 bits, then on the 8th rise:
    - `mem[ptr] <= byte`.
    - `wr_valid` pulses with `wr_addr=ptr` and `wr_data=byte`.
    - `ptr <= ptr+1` modulo DEPTH.
    - ACK, then return to WDATA.
  - **RDATA:** `sda_oe = ~shift[7]`; shift on each SCL fall. After bit 8, release SDA at the fall. On the 9th rise, sample the master ACK and set `ptr <= ptr+1` modulo DEPTH.
    - ACK (0): load `mem[ptr+1]` and drive its MSB at the next fall.
    - NACK (1): go to IGNORE.
- **Wrap-around:** the pointer wraps `DEPTH-1 → 0` for both reads and writes. There is no limit on burst length.
- **Host read port:** `rd_data <= mem[rd_addr]` every cycle. If an I2C write hits the same index in that cycle, `rd_data` shows the old value; the new value appears one cycle later.
- **Not supported:** clock stretching, general call, 10-bit addressing.

## Timing
- Required clock ratio: SCL high and low phases ≥ 4 `clk` periods each. SDA setup/hold around SCL edges ≥ 4 `clk` periods. A 25 MHz `clk` with 400 kHz SCL meets this.
- Event latency: an SCL edge on the pin is acted on 3 `clk` cycles later. The `sda_oe` change is registered on that cycle.
- `wr_valid` asserts 3 cycles after the 8th SCL rise of a data byte and lasts exactly 1 cycle.
- `rd_data` latency: 1 cycle after `rd_addr` changes.
- `busy` rises 3 cycles after the SDA fall of START and falls 3 cycles after the SDA rise of STOP.
- `rst` asserted mid-transfer clears `sda_oe` and `mem` immediately (asynchronously). On release, the block is in IDLE and waits for a fresh START.

## Test plan
- **Write burst:** START, 0xA0, 0x02, 0xDE, 0xAD, STOP.
  - `sda_oe`=1 during all four 9th clocks.
  - `wr_valid` pulses with (2,0xDE) then (3,0xAD).
  - `rd_addr`=3 gives `rd_data`=0xAD one cycle later.
- **Pointer wrap:** START, 0xA0, 0x07, 0x11, 0x22, STOP.
  - `mem[7]`=0x11 and `mem[0]`=0x22.
- **Random read with repeated start:** after the write burst, START, 0xA0, 0x03, Sr, 0xA1; master ACKs the first byte and NACKs the second.
  - SDA carries 0xAD, then 0x00 (`mem[4]`).
  - `sda_oe` is released after the NACK; STOP gives `busy`=0.
- **Address mismatch:** START, 0xA2, 0x01, 0x55, STOP.
  - `sda_oe` stays 0 for the whole transfer; no `wr_valid`.
- **Aborted byte:** START, 0xA0, 0x01, 4 data bits, STOP.
  - No `wr_valid`; `mem[1]` unchanged; `busy`=0; block is in IDLE.
- **Reset mid-read:** assert `rst` while the target is driving a 0 bit.
  - `sda_oe`=0 in the same cycle; all `mem` reads back 0.
  - After release, a new write transaction is ACKed normally.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target exposing a byte-addressed register file at a fixed 7-bit address.
// Latency: bus edges act 3 clk after the pin; wr_valid 3 clk after 8th SCL rise; rd_data 1 clk.
// Backpressure: none; no clock stretching, so the host must meet the SCL/clk ratio.
module i2c_target_regfile #(
  parameter logic [6:0] ADDR  = 7'h50,
  parameter int         DEPTH = 8,
  localparam int        AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_IGNORE, ST_ADDR_ACK, ST_REG, ST_WDATA, ST_RDATA
  } state_t;

  state_t        state;
  logic [2:0]    scl_q;
  logic [2:0]    sda_q;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          rw;
  logic [AW-1:0] ptr;
  logic [7:0]    mem [DEPTH];

  // [1] is the synchronized level, [2] the previous level for edge detection
  logic scl, scl_prev, sda, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]    rx_byte;
  logic [AW-1:0] ptr_inc;

  assign scl       = scl_q[1];
  assign scl_prev  = scl_q[2];
  assign sda       = sda_q[1];
  assign sda_prev  = sda_q[2];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & sda_prev & ~sda;
  assign stop_det  = scl & ~sda_prev & sda;
  assign rx_byte   = {shift[6:0], sda};
  assign ptr_inc   = ptr + 1'b1;

  // Synchronize the bus lines; reset to the idle-high bus level so release is quiet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  // Protocol state machine, register file and host read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      rw       <= 1'b0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_data  <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      rd_data  <= mem[rd_addr];
      if (start_det) begin
        // Repeated start keeps the pointer so a random read can follow a pointer write
        state   <= ST_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift <= rx_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd8;
                if (rx_byte[7:1] == ADDR) begin
                  rw    <= rx_byte[0];
                  state <= ST_ADDR_ACK;
                end else begin
                  state <= ST_IGNORE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_ADDR_ACK: begin
            // First fall starts the ACK, second fall (after the 9th clock) ends it
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                bit_cnt <= '0;
                if (rw) begin
                  state  <= ST_RDATA;
                  shift  <= mem[ptr];
                  sda_oe <= ~mem[ptr][7];
                end else begin
                  state  <= ST_REG;
                  sda_oe <= 1'b0;
                end
              end
            end
          end
          ST_REG, ST_WDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                if (state == ST_REG) begin
                  ptr <= rx_byte[AW-1:0];
                end else begin
                  mem[ptr] <= rx_byte;
                  wr_valid <= 1'b1;
                  wr_addr  <= ptr;
                  wr_data  <= rx_byte;
                  ptr      <= ptr_inc;
                end
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                state   <= ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              if (bit_cnt == 4'd8) begin
                // 9th rise: master ACK continues the burst, NACK ends it
                ptr <= ptr_inc;
                if (sda) begin
                  state <= ST_IGNORE;
                end else begin
                  shift   <= mem[ptr_inc];
                  bit_cnt <= '0;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else if (scl_fall) begin
              if (bit_cnt == 4'd0) begin
                sda_oe <= ~shift[7];
              end else if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
